instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Decoupling FIFO between instruction fetch and instruction decode in the Tomasulo core.
- Buffers fetched {pc, instr, predicted-taken} triples so fetch continues while decode stalls on full reservation stations or a full ROB.
- Flushed by the ROB misprediction/reset signal so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PC_W, 32, PC width in bits.
- INSTR_W, 32, instruction width in bits.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  synchronous discard of all entries (driven by ROB resetAll).
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  queue can accept; equals !full.
- in_pc  input  PC_W  PC of the fetched instruction.
- in_instr  input  INSTR_W  fetched instruction word.
- in_pred  input  1  branch predictor taken bit for this PC.
- out_valid  output  1  head entry is present; equals !empty.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  PC_W  head PC.
- out_instr  output  INSTR_W  head instruction.
- out_pred  output  1  head predicted-taken bit.
- count  output  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage: DEPTH-entry register array, head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH, and an occupancy counter.
- Reset (async): head=0, tail=0, count=0; out_valid=0, in_ready=1. out_pc, out_instr and out_pred read 0 because storage is cleared.
- Push: in_valid && in_ready at a rising edge writes the triple at tail, then tail+1.
- Pop: out_valid && out_ready at a rising edge advances head by 1.
- Output latency: out_* are driven from the head entry combinationally, with no combinational path from in_*.
  - Fetch-to-visible latency is 1 cycle: an entry pushed at edge N is visible after edge N.
  - Maximum throughput is 1 entry per cycle, sustained.
- in_ready depends only on count. No combinational path from out_ready.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Fetch must hold in_* stable until in_ready.
- Simultaneous push and pop when neither full nor empty: both occur and count is unchanged.
- Pop when empty is ignored: out_valid=0 masks it. Push when full is ignored.
- Flush:
  - Next edge sets head=tail=0 and count=0. Any push or pop in the same cycle is discarded.
  - Flush has priority over push and pop.
  - Entry contents need not be cleared, but out_valid must be 0 the cycle after flush.
- Reset mid-operation: all entries lost immediately (async). Outputs go to their reset values without waiting for an edge.
- count is always in 0..DEPTH. full = (count==DEPTH), empty = (count==0).
- Wrap-around is transparent: FIFO order is preserved across pointer wrap.

Test Plan:
- Reset then push 3 entries (pc 0x0,0x4,0x8), out_ready=0 -> count=3, out_pc=0x0; then pop 3 -> out_pc sequence 0x0,0x4,0x8, count back to 0, out_valid=0.
- Fill 4 entries (DEPTH=4) -> in_ready=0, count=4. A 5th push with pc 0x10 held, plus one pop -> pc 0x10 not accepted that cycle; accepted on the following cycle, count=4.
- Continuous push and pop for 10 cycles with pcs 0x0..0x24 step 4 -> count steady at 1; output order matches input including across 2 pointer wraps. out_pred propagates alternating 1/0 pattern unchanged.
- With 3 entries held, assert flush together with in_valid (pc 0x40) and out_ready -> next cycle count=0, out_valid=0. Following push of 0x44 appears as head with 0x40 absent.
- With 2 entries held, assert reset between edges -> out_valid=0, count=0, in_ready=1 immediately, before the next clock edge.
- Pop while empty (out_ready=1, in_valid=0) for 3 cycles -> count remains 0 and pointers unchanged. A subsequent push at pc 0x8 appears as head.

Source files
------------

// File: rtl/instr_queue.sv
// Decoupling FIFO between instruction fetch and decode. Holds {pc, instr, pred}
// triples; flushed synchronously on misprediction, cleared asynchronously on reset.
module instr_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic                       in_pred,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  output logic                       out_pred,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic               pred_mem  [DEPTH];
  logic [AW-1:0]      head;
  logic [AW-1:0]      tail;
  logic               push;
  logic               pop;

  // Handshakes depend only on occupancy, so no path from out_ready to in_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_pc    = pc_mem[head];
  assign out_instr = instr_mem[head];
  assign out_pred  = pred_mem[head];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
        pred_mem[i]  <= 1'b0;
      end
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[tail]    <= in_pc;
        instr_mem[tail] <= in_instr;
        pred_mem[tail]  <= in_pred;
        tail            <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Scoreboard bench for instr_queue: accepted pushes are queued as expected
// entries and compared against the head whenever decode consumes it.
module tb_instr_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pred;
  } ent_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_pc = '0;
  logic [31:0]   in_instr = '0;
  logic          in_pred = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic          out_pred;
  logic [CW-1:0] count;

  int   vectors = 0;
  int   miscompares = 0;
  ent_t sb[$];

  instr_queue #(.DEPTH(DEPTH), .PC_W(32), .INSTR_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_pred   (in_pred),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_pred  (out_pred),
    .count     (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {pc[15:0] ^ 16'h5a3c, ~pc[15:0]};
  endfunction

  // One clock cycle: drive, check pre-edge outputs against the scoreboard, update model.
  task automatic step(input logic v, input logic [31:0] pc, input logic pred,
                      input logic ordy, input logic fl);
    bit do_push, do_pop;
    ent_t e;
    @(negedge clock);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = mk_instr(pc);
    in_pred   = pred;
    out_ready = ordy;
    flush     = fl;
    #1;
    check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    check("in_ready", 64'(in_ready), 64'(sb.size() < DEPTH));
    do_push = v && (sb.size() < DEPTH);
    do_pop  = ordy && (sb.size() != 0);
    if (sb.size() != 0) begin
      check("head_pc", 64'(out_pc), 64'(sb[0].pc));
      if (do_pop) begin
        check("head_instr", 64'(out_instr), 64'(sb[0].instr));
        check("head_pred", 64'(out_pred), 64'(sb[0].pred));
      end
    end
    @(posedge clock);
    #1;
    if (fl) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        e.pc = pc; e.instr = mk_instr(pc); e.pred = pred;
        sb.push_back(e);
      end
    end
    check("count", 64'(count), 64'(sb.size()));
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state, observed while reset is held
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_pc", 64'(out_pc), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_pred", 64'(out_pred), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    // Push three, hold, then pop three in order
    for (int i = 0; i < 3; i++) step(1'b1, 32'(4 * i), i[0], 1'b0, 1'b0);
    check("three_count", 64'(count), 64'd3);
    check("three_head", 64'(out_pc), 64'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    check("drained_valid", 64'(out_valid), 64'd0);

    // Fill, then a held push with a pop is refused that cycle and taken next
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 32'h10, 1'b0, 1'b1, 1'b0);
    check("refused_count", 64'(count), 64'd3);
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    check("accepted_count", 64'(count), 64'd4);
    drain();

    // Sustained push+pop across pointer wraps, alternating pred
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) step(1'b1, 32'(4 * i), ~i[0], 1'b1, 1'b0);
    check("stream_count", 64'(count), 64'd1);
    drain();

    // Flush with concurrent push and pop discards everything
    for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h40, 1'b1, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    step(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
    check("post_flush_head", 64'(out_pc), 64'h44);
    drain();

    // Async reset between edges with two entries held
    step(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h304, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_count", 64'(count), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_out_pc", 64'(out_pc), 64'd0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;

    // Pops on empty are ignored; a later push becomes the head
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0);
    check("empty_pop_head", 64'(out_pc), 64'h8);
    check("empty_pop_pred", 64'(out_pred), 64'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
